// File: rtl/kv_table_writer.sv
// Registered key/value table driven as a packed kv_pairs bus, with an insert/update/delete
// write port and a single-entry registered reverse-lookup (data -> key) response stage.
module kv_table_writer #(
   parameter int unsigned NUM_KEY  = 4,
   parameter int unsigned KEY_LEN  = 4,
   parameter int unsigned DATA_LEN = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_valid,
   input  logic                          wr_del,
   input  logic [KEY_LEN-1:0]            wr_key,
   input  logic [DATA_LEN-1:0]           wr_data,
   output logic                          wr_err,
   input  logic                          lk_valid,
   output logic                          lk_ready,
   input  logic [DATA_LEN-1:0]           lk_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_hit,
   output logic [KEY_LEN-1:0]            rsp_key,
   output logic [NUM_KEY*(KEY_LEN+DATA_LEN)-1:0] kv_pairs,
   output logic [NUM_KEY-1:0]            entry_valid,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

   logic [NUM_KEY-1:0]                valid_q, valid_d;
   logic [NUM_KEY-1:0][KEY_LEN-1:0]   key_q, key_d;
   logic [NUM_KEY-1:0][DATA_LEN-1:0]  data_q, data_d;
   logic                              wr_err_q, wr_err_d;
   logic                              rsp_valid_q, rsp_valid_d;
   logic                              rsp_hit_q, rsp_hit_d;
   logic [KEY_LEN-1:0]                rsp_key_q, rsp_key_d;

   logic [NUM_KEY-1:0]                match_oh;
   logic [NUM_KEY-1:0]                free_oh;
   logic                              any_match;
   logic                              any_free;
   logic                              lk_hit;
   logic [KEY_LEN-1:0]                lk_key;
   logic                              lk_ready_c;
   logic [NUM_KEY*PAIR_LEN-1:0]       kv_pairs_c;

   // Key match against the write command and lowest-index free slot, both one-hot
   always_comb begin
      match_oh  = '0;
      free_oh   = '0;
      any_match = 1'b0;
      any_free  = 1'b0;
      for (int i = 0; i < int'(NUM_KEY); i++) begin
         if (valid_q[i] && (key_q[i] == wr_key)) begin
            match_oh[i] = 1'b1;
            any_match   = 1'b1;
         end
      end
      for (int i = 0; i < int'(NUM_KEY); i++) begin
         if (!valid_q[i] && !any_free) begin
            free_oh[i] = 1'b1;
            any_free   = 1'b1;
         end
      end
   end

   // Table next state: delete, update in place, allocate, or reject when full
   always_comb begin
      valid_d  = valid_q;
      key_d    = key_q;
      data_d   = data_q;
      wr_err_d = 1'b0;
      if (wr_valid) begin
         if (wr_del) begin
            for (int i = 0; i < int'(NUM_KEY); i++) begin
               if (match_oh[i]) begin
                  valid_d[i] = 1'b0;
                  key_d[i]   = '0;
                  data_d[i]  = '0;
               end
            end
         end else if (any_match) begin
            for (int i = 0; i < int'(NUM_KEY); i++) begin
               if (match_oh[i]) begin
                  data_d[i] = wr_data;
               end
            end
         end else if (any_free) begin
            for (int i = 0; i < int'(NUM_KEY); i++) begin
               if (free_oh[i]) begin
                  valid_d[i] = 1'b1;
                  key_d[i]   = wr_key;
                  data_d[i]  = wr_data;
               end
            end
         end else begin
            wr_err_d = 1'b1;
         end
      end
   end

   // Reverse lookup over the pre-write table, lowest index wins
   always_comb begin
      lk_hit = 1'b0;
      lk_key = '0;
      for (int i = 0; i < int'(NUM_KEY); i++) begin
         if (!lk_hit && valid_q[i] && (data_q[i] == lk_data)) begin
            lk_hit = 1'b1;
            lk_key = key_q[i];
         end
      end
   end

   // Response stage: hold while stalled, replace on accept, drop on bare consume
   always_comb begin
      lk_ready_c  = !rsp_valid_q || rsp_ready;
      rsp_valid_d = rsp_valid_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_key_d   = rsp_key_q;
      if (lk_valid && lk_ready_c) begin
         rsp_valid_d = 1'b1;
         rsp_hit_d   = lk_hit;
         rsp_key_d   = lk_key;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Invalid entries appear as all-zero pairs on the bus
   always_comb begin
      kv_pairs_c = '0;
      for (int i = 0; i < int'(NUM_KEY); i++) begin
         if (valid_q[i]) begin
            kv_pairs_c[PAIR_LEN*i +: PAIR_LEN] = {key_q[i], data_q[i]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         key_q       <= '0;
         data_q      <= '0;
         wr_err_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_key_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         key_q       <= key_d;
         data_q      <= data_d;
         wr_err_q    <= wr_err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_key_q   <= rsp_key_d;
      end
   end

   assign wr_err      = wr_err_q;
   assign lk_ready    = lk_ready_c;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_hit     = rsp_hit_q;
   assign rsp_key     = rsp_key_q;
   assign kv_pairs    = kv_pairs_c;
   assign entry_valid = valid_q;
   assign full        = &valid_q;
   assign empty       = ~|valid_q;

endmodule

// File: tb/tb_kv_table_writer.sv
// Self-checking bench for kv_table_writer: table model for writes, response scoreboard for lookups.
module tb_kv_table_writer;

   localparam int NK = 4;
   localparam int KL = 4;
   localparam int DL = 8;
   localparam int PL = KL + DL;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wr_valid = 1'b0;
   logic             wr_del = 1'b0;
   logic [KL-1:0]    wr_key = '0;
   logic [DL-1:0]    wr_data = '0;
   logic             wr_err;
   logic             lk_valid = 1'b0;
   logic             lk_ready;
   logic [DL-1:0]    lk_data = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic             rsp_hit;
   logic [KL-1:0]    rsp_key;
   logic [NK*PL-1:0] kv_pairs;
   logic [NK-1:0]    entry_valid;
   logic             full;
   logic             empty;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic          hit;
      logic [KL-1:0] key;
   } rsp_t;

   rsp_t          exp_q[$];
   logic          m_valid[NK];
   logic [KL-1:0] m_key[NK];
   logic [DL-1:0] m_data[NK];

   kv_table_writer #(.NUM_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_del(wr_del), .wr_key(wr_key), .wr_data(wr_data), .wr_err(wr_err),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_data(lk_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_key(rsp_key),
      .kv_pairs(kv_pairs), .entry_valid(entry_valid), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   function automatic logic [NK*PL-1:0] exp_pairs();
      logic [NK*PL-1:0] r;
      r = '0;
      for (int i = 0; i < NK; i++)
         if (m_valid[i]) r[PL*i +: PL] = {m_key[i], m_data[i]};
      return r;
   endfunction

   function automatic logic [NK-1:0] exp_valid();
      logic [NK-1:0] r;
      for (int i = 0; i < NK; i++) r[i] = m_valid[i];
      return r;
   endfunction

   function automatic rsp_t model_lookup(input logic [DL-1:0] d);
      rsp_t r;
      r = '0;
      for (int i = NK - 1; i >= 0; i--)
         if (m_valid[i] && m_data[i] == d) begin
            r.hit = 1'b1;
            r.key = m_key[i];
         end
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NK; i++) begin
         m_valid[i] = 1'b0;
         m_key[i]   = '0;
         m_data[i]  = '0;
      end
   endtask

   task automatic model_write(input logic del, input logic [KL-1:0] k, input logic [DL-1:0] d,
                              output logic err);
      int mi = -1;
      int fi = -1;
      err = 1'b0;
      for (int i = 0; i < NK; i++) if (m_valid[i] && m_key[i] == k) mi = i;
      for (int i = NK - 1; i >= 0; i--) if (!m_valid[i]) fi = i;
      if (del) begin
         if (mi >= 0) begin
            m_valid[mi] = 1'b0;
            m_key[mi]   = '0;
            m_data[mi]  = '0;
         end
      end else if (mi >= 0) begin
         m_data[mi] = d;
      end else if (fi >= 0) begin
         m_valid[fi] = 1'b1;
         m_key[fi]   = k;
         m_data[fi]  = d;
      end else begin
         err = 1'b1;
      end
   endtask

   // Called just after a falling edge; returns one falling edge later with the write applied
   task automatic write_cmd(input logic del, input logic [KL-1:0] k, input logic [DL-1:0] d,
                            output logic err);
      model_write(del, k, d, err);
      wr_valid = 1'b1;
      wr_del   = del;
      wr_key   = k;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
      wr_del   = 1'b0;
   endtask

   task automatic test_reset();
      logic e;
      model_clear();
      rst_n = 1'b0;
      #1;
      n_tests++; if (entry_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", entry_valid); end
      n_tests++; if ({empty, full} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full: got %b expected 10", {empty, full}); end
      n_tests++; if ({wr_err, rsp_valid, rsp_hit, rsp_key} !== 7'd0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", {wr_err, rsp_valid, rsp_hit, rsp_key}); end
      n_tests++; if (kv_pairs !== '0) begin n_fail++; $display("FAIL reset_pairs: got %h expected 0", kv_pairs); end
      n_tests++; if (lk_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lk_ready: got %b expected 1", lk_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      e = 1'b0;
   endtask

   task automatic test_insert();
      logic e;
      write_cmd(1'b0, 4'h3, 8'hAA, e);
      n_tests++; if (wr_err !== e) begin n_fail++; $display("FAIL insert_err: got %b expected %b", wr_err, e); end
      write_cmd(1'b0, 4'h5, 8'hBB, e);
      n_tests++; if (entry_valid !== 4'b0011) begin n_fail++; $display("FAIL insert_valid: got %b expected 0011", entry_valid); end
      n_tests++; if (kv_pairs[23:0] !== 24'h5BB_3AA) begin n_fail++; $display("FAIL insert_pairs: got %h expected 5bb3aa", kv_pairs[23:0]); end
      n_tests++; if (kv_pairs !== exp_pairs()) begin n_fail++; $display("FAIL insert_model: got %h expected %h", kv_pairs, exp_pairs()); end
      n_tests++; if ({empty, full} !== 2'b00) begin n_fail++; $display("FAIL insert_empty_full: got %b expected 00", {empty, full}); end
   endtask

   task automatic test_full();
      logic e;
      logic [NK*PL-1:0] snap;
      write_cmd(1'b0, 4'h1, 8'h10, e);
      write_cmd(1'b0, 4'h2, 8'h20, e);
      n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
      snap = exp_pairs();
      write_cmd(1'b0, 4'h9, 8'h99, e);
      n_tests++; if (wr_err !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL full_err: got %b expected 1", wr_err); end
      n_tests++; if (kv_pairs !== snap) begin n_fail++; $display("FAIL full_unchanged: got %h expected %h", kv_pairs, snap); end
      @(negedge clk);
      n_tests++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL full_err_pulse: got %b expected 0", wr_err); end
      write_cmd(1'b0, 4'h3, 8'h11, e);
      n_tests++; if (kv_pairs[11:0] !== 12'h311) begin n_fail++; $display("FAIL update_entry0: got %h expected 311", kv_pairs[11:0]); end
      n_tests++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL update_err: got %b expected 0", wr_err); end
      n_tests++; if (kv_pairs !== exp_pairs()) begin n_fail++; $display("FAIL update_model: got %h expected %h", kv_pairs, exp_pairs()); end
   endtask

   task automatic test_delete();
      logic e;
      logic [NK*PL-1:0] snap;
      write_cmd(1'b1, 4'h5, 8'hFF, e);
      n_tests++; if (entry_valid !== 4'b1101) begin n_fail++; $display("FAIL delete_valid: got %b expected 1101", entry_valid); end
      n_tests++; if (kv_pairs[23:12] !== 12'h000) begin n_fail++; $display("FAIL delete_cleared: got %h expected 000", kv_pairs[23:12]); end
      write_cmd(1'b0, 4'h7, 8'hCC, e);
      n_tests++; if (kv_pairs[23:12] !== 12'h7CC) begin n_fail++; $display("FAIL realloc_slot1: got %h expected 7cc", kv_pairs[23:12]); end
      snap = exp_pairs();
      write_cmd(1'b1, 4'hE, 8'h00, e);
      n_tests++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL del_absent_err: got %b expected 0", wr_err); end
      n_tests++; if (kv_pairs !== snap || entry_valid !== 4'b1111) begin n_fail++; $display("FAIL del_absent_table: got %h expected %h", kv_pairs, snap); end
   endtask

   task automatic test_lookup();
      logic e;
      rsp_t x;
      write_cmd(1'b1, 4'h2, 8'h00, e);
      write_cmd(1'b0, 4'h5, 8'hBB, e);
      rsp_ready = 1'b1;
      lk_valid  = 1'b1;
      lk_data   = 8'hBB;
      exp_q.push_back(model_lookup(8'hBB));
      @(negedge clk);
      lk_valid = 1'b0;
      n_tests++; if ({rsp_valid, rsp_hit, rsp_key} !== 6'b1_1_0101) begin n_fail++; $display("FAIL lookup_bb: got %b expected 110101", {rsp_valid, rsp_hit, rsp_key}); end
      x = exp_q.pop_front();
      n_tests++; if ({rsp_hit, rsp_key} !== x) begin n_fail++; $display("FAIL lookup_bb_sb: got %h expected %h", {rsp_hit, rsp_key}, x); end
      @(negedge clk);
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lookup_drain: got %b expected 0", rsp_valid); end
      lk_valid = 1'b1;
      lk_data  = 8'h42;
      exp_q.push_back(model_lookup(8'h42));
      @(negedge clk);
      lk_valid = 1'b0;
      x = exp_q.pop_front();
      n_tests++; if ({rsp_valid, rsp_hit, rsp_key} !== {1'b1, x}) begin n_fail++; $display("FAIL lookup_miss: got %h expected %h", {rsp_valid, rsp_hit, rsp_key}, {1'b1, x}); end
      n_tests++; if ({rsp_hit, rsp_key} !== 5'd0) begin n_fail++; $display("FAIL lookup_miss_key: got %h expected 0", {rsp_hit, rsp_key}); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      logic e;
      rsp_t x;
      rsp_ready = 1'b0;
      lk_valid  = 1'b1;
      lk_data   = 8'h10;
      exp_q.push_back(model_lookup(8'h10));
      @(negedge clk);
      lk_data = 8'hCC;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            model_write(1'b0, 4'h1, 8'h55, e);
            wr_valid = 1'b1; wr_del = 1'b0; wr_key = 4'h1; wr_data = 8'h55;
         end
         #1;
         n_tests++; if (lk_ready !== 1'b0) begin n_fail++; $display("FAIL stall_lk_ready c%0d: got %b expected 0", c, lk_ready); end
         n_tests++; if ({rsp_valid, rsp_hit, rsp_key} !== {1'b1, exp_q[0]}) begin n_fail++; $display("FAIL stall_hold c%0d: got %h expected %h", c, {rsp_valid, rsp_hit, rsp_key}, {1'b1, exp_q[0]}); end
         @(negedge clk);
         wr_valid = 1'b0;
      end
      lk_valid  = 1'b0;
      rsp_ready = 1'b1;
      x = exp_q.pop_front();
      n_tests++; if ({rsp_valid, rsp_hit, rsp_key} !== {1'b1, x} || x !== 5'b1_0001) begin n_fail++; $display("FAIL stall_release: got %h expected %h", {rsp_valid, rsp_hit, rsp_key}, {1'b1, x}); end
      @(negedge clk);
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b expected 0", rsp_valid); end
      n_tests++; if (kv_pairs[35:24] !== 12'h155) begin n_fail++; $display("FAIL stall_write: got %h expected 155", kv_pairs[35:24]); end
   endtask

   task automatic test_back_to_back();
      logic [DL-1:0] stream[6];
      rsp_t x;
      stream = '{8'h11, 8'hCC, 8'h42, 8'hBB, 8'h55, 8'h10};
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         lk_valid = 1'b1;
         lk_data  = stream[k];
         exp_q.push_back(model_lookup(stream[k]));
         #1;
         n_tests++; if (lk_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready %0d: got %b expected 1", k, lk_ready); end
         @(negedge clk);
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++; $display("FAIL b2b_queue %0d: got empty expected entry", k);
         end else begin
            x = exp_q.pop_front();
            n_tests++; if ({rsp_valid, rsp_hit, rsp_key} !== {1'b1, x}) begin n_fail++; $display("FAIL b2b_rsp %0d: got %h expected %h", k, {rsp_valid, rsp_hit, rsp_key}, {1'b1, x}); end
         end
      end
      lk_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_same_cycle();
      logic e;
      rsp_t x;
      rsp_ready = 1'b1;
      lk_valid  = 1'b1;
      lk_data   = 8'h22;
      exp_q.push_back(model_lookup(8'h22));
      write_cmd(1'b0, 4'h3, 8'h22, e);
      lk_valid = 1'b0;
      x = exp_q.pop_front();
      n_tests++; if ({rsp_valid, rsp_hit, rsp_key} !== {1'b1, x} || x.hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_prewrite: got %h expected %h", {rsp_valid, rsp_hit, rsp_key}, {1'b1, x}); end
      n_tests++; if (kv_pairs[11:0] !== 12'h322) begin n_fail++; $display("FAIL same_cycle_write: got %h expected 322", kv_pairs[11:0]); end
      write_cmd(1'b0, 4'h7, 8'h22, e);
      lk_valid = 1'b1;
      lk_data  = 8'h22;
      exp_q.push_back(model_lookup(8'h22));
      @(negedge clk);
      lk_valid = 1'b0;
      x = exp_q.pop_front();
      n_tests++; if ({rsp_valid, rsp_hit, rsp_key} !== {1'b1, x} || x !== 5'b1_0011) begin n_fail++; $display("FAIL lowest_index_hit: got %h expected %h", {rsp_valid, rsp_hit, rsp_key}, {1'b1, x}); end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic e;
      rsp_ready = 1'b0;
      lk_valid  = 1'b1;
      lk_data   = 8'hBB;
      exp_q.push_back(model_lookup(8'hBB));
      @(negedge clk);
      lk_valid = 1'b0;
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pending: got %b expected 1", rsp_valid); end
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      model_clear();
      #1;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL areset_rsp: got %b expected 0", rsp_valid); end
      n_tests++; if (entry_valid !== 4'b0000 || empty !== 1'b1) begin n_fail++; $display("FAIL areset_table: got %b expected 0000", entry_valid); end
      n_tests++; if (kv_pairs !== '0) begin n_fail++; $display("FAIL areset_pairs: got %h expected 0", kv_pairs); end
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      write_cmd(1'b0, 4'h4, 8'h44, e);
      n_tests++; if (entry_valid !== 4'b0001 || kv_pairs !== exp_pairs()) begin n_fail++; $display("FAIL post_reset_insert: got %h expected %h", kv_pairs, exp_pairs()); end
   endtask

   initial begin
      test_reset();
      test_insert();
      test_full();
      test_delete();
      test_lookup();
      test_stall();
      test_back_to_back();
      test_same_cycle();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/kv_table_writer.md
Name: kv_table_writer

Overview:
- Owns a small registered key/value table and drives it as a packed `kv_pairs` bus, in the exact layout our key-to-data selector consumes.
- Accepts insert, update and delete commands through a write port.
- Also answers reverse lookups (data in, key out) through a valid/ready request/response pair.
- Sits beside decode/control logic that builds selector tables at run time instead of hard-coding them.

Parameters:
- NUM_KEY, 4, number of table entries.
- KEY_LEN, 4, key width in bits.
- DATA_LEN, 8, data width in bits.
- PAIR_LEN (localparam), KEY_LEN+DATA_LEN, width of one packed pair.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  write command present; always accepted (no ready).
- wr_del  input  1  1 = delete, 0 = insert/update.
- wr_key  input  KEY_LEN  command key.
- wr_data  input  DATA_LEN  command data; ignored on delete.
- wr_err  output  1  one-cycle pulse: insert rejected because table full.
- lk_valid  input  1  reverse-lookup request valid.
- lk_ready  output  1  request accepted when lk_valid && lk_ready.
- lk_data  input  DATA_LEN  data value to search for.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_hit  output  1  1 = match found.
- rsp_key  output  KEY_LEN  matched key; 0 on miss.
- kv_pairs  output  NUM_KEY*PAIR_LEN  packed table contents.
- entry_valid  output  NUM_KEY  per-entry valid bits.
- full  output  1  all entries valid.
- empty  output  1  no entry valid.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): all entries invalid; key/data registers 0; wr_err=0, rsp_valid=0, rsp_hit=0, rsp_key=0; full=0, empty=1.
- Reset mid-operation discards any pending response.
- Storage: per entry i, valid[i], key[i], data[i].
- kv_pairs slice [PAIR_LEN*(i+1)-1 : PAIR_LEN*i] = {key[i], data[i]} when valid[i], else all zeros. Key in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
- Write, evaluated on each cycle with wr_valid=1; all effects visible on outputs the cycle after the edge:
  - Key match = valid[i] && key[i]==wr_key. Keys are unique by construction, so at most one entry matches.
  - Insert with match: data[i] <= wr_data (update in place; index unchanged).
  - Insert with no match, not full: allocate the lowest-index invalid entry; set valid, key and data.
  - Insert with no match, full: table unchanged; wr_err=1 for exactly one cycle.
  - Delete with match: valid[i] <= 0; key[i] and data[i] cleared to 0.
  - Delete with no match: no-op; wr_err stays 0.
- wr_err is 0 in every cycle not covered by the rejected-insert case.
- full = &valid and empty = ~|valid, both derived from registered state.
- Lookup response stage (single entry, registered):
  - lk_ready = !rsp_valid || rsp_ready.
  - On accept: search valid entries for data[i]==lk_data. The lowest-index match wins, giving rsp_hit=1 and rsp_key=key[i]. On no match, rsp_hit=0 and rsp_key=0.
  - rsp_valid is set the next cycle, giving 1-cycle latency.
  - rsp_valid, rsp_hit and rsp_key hold stable while rsp_valid && !rsp_ready.
  - Accept and consume in the same cycle: the new response replaces the old one; throughput is 1 per cycle.
  - Consume with no new accept: rsp_valid <= 0.
- Write and lookup in the same cycle: the lookup searches the pre-write table.
- A stalled response is not re-evaluated after later writes.
- Width rules: all compares are full-width equality; no arithmetic.
- Free-slot and match selection are fixed priority, lowest index first.

Test Plan:
- Reset, then insert (3,0xAA), (5,0xBB) -> entry_valid=0011; kv_pairs low pair = {4'h3,8'hAA}, next pair = {4'h5,8'hBB}; empty=0, full=0.
- Fill all 4 entries, then insert key 9 -> wr_err high for one cycle; kv_pairs unchanged; full=1. Insert existing key 3 with 0x11 -> entry 0 data=0x11; wr_err=0.
- Delete key 5 (entry 1), then insert (7,0xCC) -> lands in entry 1. Delete absent key 0xE -> no change, wr_err=0.
- Lookup 0xBB with rsp_ready=1 -> next cycle rsp_valid=1, rsp_hit=1, rsp_key=5. Lookup 0x42 -> rsp_hit=0, rsp_key=0.
- Hold rsp_ready=0 for 3 cycles with a response pending -> lk_ready=0, response fields stable. Issue a back-to-back lookup stream with rsp_ready=1 -> one response per cycle, in order.
- In the same cycle, update key 3 to 0x22 and look up 0x22 -> miss (pre-write table). Assert rst_n=0 with rsp_valid=1 -> rsp_valid=0 and entry_valid=0 immediately, without waiting for a clock edge.
